// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave serving 32-bit bursts from one single-port synchronous SRAM
// Independent read/write FSMs (one transaction each) share the SRAM port through a fair arbiter.
module axi_sram_slave #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic        init_done_q, init_done_d;
  logic        prio_w_q, prio_w_d;
  logic [3:0]  rid_q, rid_d, bid_q, bid_d;
  logic [31:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic [7:0]  rlen_q, rlen_d, wlen_q, wlen_d;
  logic [7:0]  rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic [2:0]  rsize_q, rsize_d, wsize_q, wsize_d;
  logic [1:0]  rburst_q, rburst_d, wburst_q, wburst_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d, rlast_q, rlast_d, bvalid_q, bvalid_d;
  logic        req_r, req_w, gnt_r, gnt_w;
  logic        unused_ok;

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] step, mask;
    step = 32'd1 << sz;
    mask = (({24'd0, len} + 32'd1) << sz) - 32'd1;
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + step) & mask);
      default: next_addr = a + step;
    endcase
  endfunction

  // Grant is combinational; on contention the side not served last wins.
  assign req_r = (r_state_q == R_REQ);
  assign req_w = (w_state_q == W_DATA) && wvalid;
  assign gnt_w = req_w && (!req_r || prio_w_q);
  assign gnt_r = req_r && !gnt_w;

  assign arready   = init_done_q && (r_state_q == R_IDLE);
  assign awready   = init_done_q && (w_state_q == W_IDLE);
  assign wready    = gnt_w;
  assign ram_en    = gnt_r || gnt_w;
  assign ram_wen   = gnt_w ? wstrb : 4'b0000;
  assign ram_addr  = gnt_w ? waddr_q[ADDR_W+1:2] : raddr_q[ADDR_W+1:2];
  assign ram_wdata = wdata;
  assign rid       = rid_q;
  assign rdata     = rdata_q;
  assign rresp     = 2'b00;
  assign rlast     = rlast_q;
  assign rvalid    = rvalid_q;
  assign bid       = bid_q;
  assign bresp     = 2'b00;
  assign bvalid    = bvalid_q;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, wlast};

  always_comb begin
    r_state_d = r_state_q;  w_state_d = w_state_q;
    init_done_d = 1'b1;     prio_w_d = prio_w_q;
    rid_d = rid_q;          bid_d = bid_q;
    raddr_d = raddr_q;      waddr_d = waddr_q;
    rlen_d = rlen_q;        wlen_d = wlen_q;
    rcnt_d = rcnt_q;        wcnt_d = wcnt_q;
    rsize_d = rsize_q;      wsize_d = wsize_q;
    rburst_d = rburst_q;    wburst_d = wburst_q;
    rdata_d = rdata_q;      rvalid_d = rvalid_q;
    rlast_d = rlast_q;      bvalid_d = bvalid_q;
    if (gnt_r) prio_w_d = 1'b1;
    if (gnt_w) prio_w_d = 1'b0;

    case (r_state_q)
      R_IDLE: if (arvalid && arready) begin
        rid_d = arid; raddr_d = araddr; rlen_d = arlen; rsize_d = arsize; rburst_d = arburst;
        rcnt_d = 8'd0; r_state_d = R_REQ;
      end
      R_REQ: if (gnt_r) r_state_d = R_WAIT;
      R_WAIT: begin
        rdata_d = ram_rdata; rvalid_d = 1'b1; rlast_d = (rcnt_q == rlen_q);
        r_state_d = R_RESP;
      end
      default: if (rready) begin
        rvalid_d = 1'b0; rlast_d = 1'b0;
        if (rlast_q) r_state_d = R_IDLE;
        else begin
          raddr_d = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
          rcnt_d = rcnt_q + 8'd1; r_state_d = R_REQ;
        end
      end
    endcase

    case (w_state_q)
      W_IDLE: if (awvalid && awready) begin
        bid_d = awid; waddr_d = awaddr; wlen_d = awlen; wsize_d = awsize; wburst_d = awburst;
        wcnt_d = 8'd0; w_state_d = W_DATA;
      end
      W_DATA: if (gnt_w) begin
        if (wcnt_q == wlen_q) begin
          bvalid_d = 1'b1; w_state_d = W_RESP;
        end else begin
          waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: if (bready) begin
        bvalid_d = 1'b0; w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;  w_state_q <= W_IDLE;
      init_done_q <= 1'b0;  prio_w_q <= 1'b1;
      rid_q <= '0;   bid_q <= '0;   raddr_q <= '0;  waddr_q <= '0;
      rlen_q <= '0;  wlen_q <= '0;  rcnt_q <= '0;   wcnt_q <= '0;
      rsize_q <= '0; wsize_q <= '0; rburst_q <= '0; wburst_q <= '0;
      rdata_q <= '0; rvalid_q <= 1'b0; rlast_q <= 1'b0; bvalid_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;  w_state_q <= w_state_d;
      init_done_q <= init_done_d;  prio_w_q <= prio_w_d;
      rid_q <= rid_d;     bid_q <= bid_d;     raddr_q <= raddr_d;   waddr_q <= waddr_d;
      rlen_q <= rlen_d;   wlen_q <= wlen_d;   rcnt_q <= rcnt_d;     wcnt_q <= wcnt_d;
      rsize_q <= rsize_d; wsize_q <= wsize_d; rburst_q <= rburst_d; wburst_q <= wburst_d;
      rdata_q <= rdata_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d; bvalid_q <= bvalid_d;
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - self-checking bench for axi_sram_slave
// Scenario tasks drive AXI traffic and compare against a word-level memory model.
module tb_axi_sram_slave;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic resetn;
  logic [3:0] arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata, ram_wdata, ram_rdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0] arcache, awcache, wstrb, ram_wen;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready, ram_en;
  logic [ADDR_W-1:0] ram_addr;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] sram [DEPTH];
  logic pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] ref_mem [int];

  logic [31:0] rq_data[$];
  logic        rq_last[$];
  logic [3:0]  rq_id[$];
  logic [1:0]  rq_resp[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  bit          gnt_log[$];
  bit          mon_en = 1'b0;

  axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_wen == 4'b0000) ram_rdata <= sram[ram_addr];
      else for (int b = 0; b < 4; b++)
        if (ram_wen[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    #2;
    if (mon_en && ram_en) gnt_log.push_back(ram_wen != 4'b0000);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Byte address of beat i, straight from the burst definition.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i, input logic [2:0] sz,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] step, span, base;
    step = 32'd1 << sz;
    if (burst == 2'b00) return start;
    if (burst == 2'b10) begin
      span = (32'(len) + 32'd1) * step;
      base = start - (start % span);
      return base + ((start - base + 32'(i) * step) % span);
    end
    return start + 32'(i) * step;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a[ADDR_W+1:2]; pl_data = v;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[widx(a)] = v;
  endtask

  task automatic model_write(input logic [31:0] start, input logic [7:0] len, input logic [2:0] sz,
                             input logic [1:0] burst, input int nbeats);
    logic [31:0] a, w;
    for (int i = 0; i < nbeats; i++) begin
      a = beat_addr(start, i, sz, len, burst);
      w = ref_word(a);
      for (int b = 0; b < 4; b++) if (wq_strb[i][b]) w[8*b +: 8] = wq_data[i][8*b +: 8];
      ref_mem[widx(a)] = w;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] burst);
    bit ok = 1'b0;
    @(negedge clk);
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = burst; arvalid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      #1; ok = arready;
      @(negedge clk);
    end
    arvalid = 1'b0;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL ar_handshake: arready=0 for 100 cycles, required 1"); end
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] burst);
    bit ok = 1'b0;
    @(negedge clk);
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = burst; awvalid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      #1; ok = awready;
      @(negedge clk);
    end
    awvalid = 1'b0;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL aw_handshake: awready=0 for 100 cycles, required 1"); end
  endtask

  task automatic read_beats(input int n, input bit rnd);
    int got = 0;
    rq_data.delete(); rq_last.delete(); rq_id.delete(); rq_resp.delete();
    for (int c = 0; c < 3000 && got < n; c++) begin
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rvalid && rready) begin
        rq_data.push_back(rdata); rq_last.push_back(rlast);
        rq_id.push_back(rid); rq_resp.push_back(rresp);
        got++;
      end
      @(negedge clk);
    end
    rready = 1'b0;
    n_cmp++;
    if (got != n) begin n_fail++; $display("FAIL read_beats: got %0d beats, required %0d", got, n); end
  endtask

  task automatic write_beats(input int n, input bit rnd);
    int sent = 0;
    for (int c = 0; c < 3000 && sent < n; c++) begin
      wvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata = wq_data[sent]; wstrb = wq_strb[sent]; wlast = (sent == n - 1);
      #1;
      if (wvalid && wready) sent++;
      @(negedge clk);
    end
    wvalid = 1'b0;
    n_cmp++;
    if (sent != n) begin n_fail++; $display("FAIL write_beats: sent %0d beats, required %0d", sent, n); end
  endtask

  task automatic wait_b(input bit rnd);
    bit got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bvalid && bready) begin b_id = bid; b_resp = bresp; got = 1'b1; end
      @(negedge clk);
    end
    bready = 1'b0;
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL wait_b: no write response in 300 cycles, required one"); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({arready, awready, wready, rvalid, bvalid, ram_en, rlast, ram_wen, rid, bid} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ar/aw/w ready=%b%b%b rvalid=%b bvalid=%b ram_en=%b rlast=%b wen=%h rid=%h bid=%h, required all 0",
               arready, awready, wready, rvalid, bvalid, ram_en, rlast, ram_wen, rid, bid);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_cmp++;
    if ({arready, awready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release_ready: arready/awready=%b%b before first edge, required 00", arready, awready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({arready, awready} !== 2'b11) begin
      n_fail++; $display("FAIL init_done_ready: arready/awready=%b%b after first edge, required 11", arready, awready);
    end
  endtask

  task automatic test_single_read();
    preload(32'h100, 32'hDEADBEEF);
    rready = 1'b0;
    do_ar(4'd3, 32'h100, 8'd0, 3'd2, 2'b01);
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_cmp++;
      if (rvalid !== (c == 3)) begin
        n_fail++; $display("FAIL rvalid_latency: at T+%0d rvalid=%b, required %b", c, rvalid, (c == 3));
      end
      @(negedge clk);
    end
    read_beats(1, 1'b0);
    n_cmp++;
    if (rq_data.size() != 1 || rq_data[0] !== 32'hDEADBEEF || rq_id[0] !== 4'd3 || rq_last[0] !== 1'b1 || rq_resp[0] !== 2'b00) begin
      n_fail++; $display("FAIL single_read: data=%h id=%h last=%b resp=%h, required DEADBEEF 3 1 0",
                         rq_data[0], rq_id[0], rq_last[0], rq_resp[0]);
    end
  endtask

  task automatic test_incr_burst();
    wq_data = '{32'd1, 32'd2, 32'd3, 32'd4};
    wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_aw(4'd5, 32'h200, 8'd3, 3'd2, 2'b01);
    write_beats(4, 1'b0);
    wait_b(1'b0);
    model_write(32'h200, 8'd3, 3'd2, 2'b01, 4);
    n_cmp++;
    if (b_id !== 4'd5 || b_resp !== 2'b00) begin
      n_fail++; $display("FAIL incr_bresp: bid=%h bresp=%h, required 5 0", b_id, b_resp);
    end
    do_ar(4'd6, 32'h200, 8'd3, 3'd2, 2'b01);
    read_beats(4, 1'b0);
    for (int i = 0; i < rq_data.size(); i++) begin
      n_cmp++;
      if (rq_data[i] !== 32'(i + 1) || rq_last[i] !== (i == 3) || rq_id[i] !== 4'd6) begin
        n_fail++; $display("FAIL incr_readback beat %0d: data=%h last=%b id=%h, required %h %b 6",
                           i, rq_data[i], rq_last[i], rq_id[i], 32'(i + 1), (i == 3));
      end
    end
  endtask

  task automatic test_strobe();
    preload(32'h40, 32'h11223344);
    wq_data = '{32'hAABBCCDD};
    wq_strb = '{4'b0101};
    do_aw(4'd1, 32'h40, 8'd0, 3'd2, 2'b01);
    write_beats(1, 1'b0);
    wait_b(1'b0);
    model_write(32'h40, 8'd0, 3'd2, 2'b01, 1);
    do_ar(4'd2, 32'h40, 8'd0, 3'd2, 2'b01);
    read_beats(1, 1'b0);
    n_cmp++;
    if (rq_data.size() != 1 || rq_data[0] !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL strobe_merge: data=%h, required 11BB33DD", rq_data[0]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp[4];
    exp = '{32'hD, 32'hA, 32'hB, 32'hC};
    preload(32'h00, 32'hA); preload(32'h04, 32'hB);
    preload(32'h08, 32'hC); preload(32'h0C, 32'hD);
    do_ar(4'd4, 32'h0C, 8'd3, 3'd2, 2'b10);
    read_beats(4, 1'b0);
    for (int i = 0; i < rq_data.size(); i++) begin
      n_cmp++;
      if (rq_data[i] !== exp[i]) begin
        n_fail++; $display("FAIL wrap_beat %0d: data=%h, required %h", i, rq_data[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    for (int i = 0; i < 4; i++) preload(32'h500 + 32'(4 * i), $urandom);
    rready = 1'b0;
    do_ar(4'd7, 32'h500, 8'd3, 3'd2, 2'b01);
    read_beats(1, 1'b0);
    for (int c = 0; c < 20 && !seen; c++) begin #1; seen = rvalid; if (!seen) @(negedge clk); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== ref_word(32'h504) || rlast !== 1'b0 || rid !== 4'd7 || ram_en !== 1'b0) begin
        n_fail++; $display("FAIL r_stall cycle %0d: rvalid=%b data=%h last=%b id=%h ram_en=%b, required 1 %h 0 7 0",
                           c, rvalid, rdata, rlast, rid, ram_en, ref_word(32'h504));
      end
    end
    @(negedge clk);
    read_beats(3, 1'b0);
    for (int i = 0; i < rq_data.size(); i++) begin
      n_cmp++;
      if (rq_data[i] !== ref_word(32'h504 + 32'(4 * i)) || rq_last[i] !== (i == 2)) begin
        n_fail++; $display("FAIL r_resume beat %0d: data=%h last=%b, required %h %b",
                           i + 1, rq_data[i], rq_last[i], ref_word(32'h504 + 32'(4 * i)), (i == 2));
      end
    end
    wq_data = '{$urandom, $urandom};
    wq_strb = '{4'hF, 4'hF};
    do_aw(4'd8, 32'h580, 8'd1, 3'd2, 2'b01);
    write_beats(2, 1'b0);
    model_write(32'h580, 8'd1, 3'd2, 2'b01, 2);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin #1; seen = bvalid; if (!seen) @(negedge clk); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (bvalid !== 1'b1 || bid !== 4'd8 || ram_en !== 1'b0) begin
        n_fail++; $display("FAIL b_stall cycle %0d: bvalid=%b bid=%h ram_en=%b, required 1 8 0", c, bvalid, bid, ram_en);
      end
    end
    @(negedge clk);
    wait_b(1'b0);
    n_cmp++;
    if (b_id !== 4'd8) begin n_fail++; $display("FAIL b_resume: bid=%h, required 8", b_id); end
  endtask

  task automatic test_concurrent();
    int nw = 0;
    for (int i = 0; i < 4; i++) preload(32'h300 + 32'(4 * i), $urandom);
    apply_reset();
    wq_data = '{$urandom, $urandom, $urandom, $urandom};
    wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    gnt_log.delete();
    mon_en = 1'b1;
    fork
      begin do_ar(4'd9, 32'h300, 8'd3, 3'd2, 2'b01); read_beats(4, 1'b0); end
      begin do_aw(4'hA, 32'h400, 8'd3, 3'd2, 2'b01); write_beats(4, 1'b0); wait_b(1'b0); end
    join
    mon_en = 1'b0;
    foreach (gnt_log[i]) if (gnt_log[i]) nw++;
    n_cmp++;
    if (gnt_log.size() != 8 || nw != 4 || gnt_log[0] !== 1'b1 || gnt_log[1] !== 1'b0) begin
      n_fail++; $display("FAIL concurrent_grants: %0d grants (%0d write), first two W=%b,%b, required 8 (4 write), 1,0",
                         gnt_log.size(), nw, gnt_log[0], gnt_log[1]);
    end
    for (int i = 0; i < rq_data.size(); i++) begin
      n_cmp++;
      if (rq_data[i] !== ref_word(32'h300 + 32'(4 * i)) || rq_id[i] !== 4'd9) begin
        n_fail++; $display("FAIL concurrent_read beat %0d: data=%h id=%h, required %h 9",
                           i, rq_data[i], rq_id[i], ref_word(32'h300 + 32'(4 * i)));
      end
    end
    n_cmp++;
    if (b_id !== 4'hA) begin n_fail++; $display("FAIL concurrent_bid: bid=%h, required a", b_id); end
    model_write(32'h400, 8'd3, 3'd2, 2'b01, 4);
    do_ar(4'd1, 32'h400, 8'd3, 3'd2, 2'b01);
    read_beats(4, 1'b0);
    for (int i = 0; i < rq_data.size(); i++) begin
      n_cmp++;
      if (rq_data[i] !== ref_word(32'h400 + 32'(4 * i))) begin
        n_fail++; $display("FAIL concurrent_writeback beat %0d: data=%h, required %h",
                           i, rq_data[i], ref_word(32'h400 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 8; i++) preload(32'h600 + 32'(4 * i), $urandom);
    rready = 1'b0;
    do_ar(4'd1, 32'h600, 8'd7, 3'd2, 2'b01);
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < 8; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
    do_aw(4'd2, 32'h700, 8'd7, 3'd2, 2'b01);
    write_beats(2, 1'b0);
    model_write(32'h700, 8'd7, 3'd2, 2'b01, 2);
    wvalid = 1'b1; rready = 1'b1; bready = 1'b1; resetn = 1'b0;
    #1;
    n_cmp++;
    if ({arready, awready, wready, rvalid, bvalid, ram_en, rlast} !== 7'd0) begin
      n_fail++; $display("FAIL async_reset: ar/aw/w ready=%b%b%b rvalid=%b bvalid=%b ram_en=%b rlast=%b, required all 0",
                         arready, awready, wready, rvalid, bvalid, ram_en, rlast);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    n_cmp++;
    if ({arready, awready} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_release: arready/awready=%b%b, required 00", arready, awready);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({rvalid, bvalid, ram_en, wready} !== 4'd0 || {arready, awready} !== 2'b11) begin
        n_fail++; $display("FAIL dropped_burst cycle %0d: rvalid=%b bvalid=%b ram_en=%b wready=%b ar/awready=%b%b, required 0 0 0 0 11",
                           c, rvalid, bvalid, ram_en, wready, arready, awready);
      end
    end
    wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
  endtask

  task automatic test_addr_wrap32();
    preload(32'h0000FFFC, 32'h5A5A0001);
    preload(32'h00000000, 32'h5A5A0002);
    do_ar(4'd3, 32'hFFFFFFFC, 8'd1, 3'd2, 2'b01);
    read_beats(2, 1'b0);
    n_cmp++;
    if (rq_data.size() != 2 || rq_data[0] !== 32'h5A5A0001 || rq_data[1] !== 32'h5A5A0002) begin
      n_fail++; $display("FAIL addr_wrap32: data=%h,%h, required 5a5a0001,5a5a0002", rq_data[0], rq_data[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] start, exp;
    logic [7:0] len;
    logic [2:0] sz;
    logic [1:0] burst;
    logic [3:0] id;
    for (int it = 0; it < 20; it++) begin
      sz = 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 3));
      len = (burst == 2'b10) ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 15));
      start = $urandom & ~((32'd1 << sz) - 32'd1);
      id = 4'($urandom);
      for (int i = 0; i <= int'(len); i++) preload(beat_addr(start, i, sz, len, burst), $urandom);
      wq_data.delete(); wq_strb.delete();
      for (int i = 0; i <= int'(len); i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'($urandom)); end
      do_aw(id, start, len, sz, burst);
      write_beats(int'(len) + 1, 1'b1);
      wait_b(1'b1);
      model_write(start, len, sz, burst, int'(len) + 1);
      n_cmp++;
      if (b_id !== id || b_resp !== 2'b00) begin
        n_fail++; $display("FAIL rand_b it %0d: bid=%h bresp=%h, required %h 0", it, b_id, b_resp, id);
      end
      do_ar(~id, start, len, sz, burst);
      read_beats(int'(len) + 1, 1'b1);
      for (int i = 0; i < rq_data.size(); i++) begin
        exp = ref_word(beat_addr(start, i, sz, len, burst));
        n_cmp++;
        if (rq_data[i] !== exp || rq_last[i] !== (i == int'(len)) || rq_id[i] !== ~id || rq_resp[i] !== 2'b00) begin
          n_fail++; $display("FAIL rand_r it %0d beat %0d (burst %0d size %0d): data=%h last=%b id=%h resp=%h, required %h %b %h 0",
                             it, i, burst, sz, rq_data[i], rq_last[i], rq_id[i], rq_resp[i], exp, (i == int'(len)), ~id);
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0; arprot = '0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0; awprot = '0;
    arvalid = 1'b0; awvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    test_reset();
    test_single_read();
    test_incr_burst();
    test_strobe();
    test_wrap();
    test_backpressure();
    test_concurrent();
    test_reset_mid_burst();
    test_addr_wrap32();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
